// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, IF/ID pipeline register, stall/redirect handling.
// Optional direct-mapped BTB enabled by defining IF_BTB_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pcp4_o,
  output logic [31:0] if_id_ins_o,
  output logic        if_id_pred_taken_o,
  output logic [31:0] fetch_cnt_o,
  output logic [15:0] flush_cnt_o,
  input  logic        btb_upd_i,
  input  logic [31:0] btb_upd_pc_i,
  input  logic [31:0] btb_upd_target_i
);

  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pcp4;
  logic [31:0] r_id_ins;
  logic        r_id_pred;
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  logic [31:0] w_pcp4;
  logic        w_hit;
  logic [31:0] w_btb_tgt;

  assign w_pcp4 = r_pc + 32'd4;

`ifdef IF_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;

  logic [BTB_ENTRIES-1:0] r_btb_v;
  logic [TW-1:0]          r_btb_tag [BTB_ENTRIES];
  logic [31:0]            r_btb_tgt [BTB_ENTRIES];

  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_upd_idx;
  logic [1:0]    w_unused;

  assign w_idx     = r_pc[IW+1:2];
  assign w_upd_idx = btb_upd_pc_i[IW+1:2];
  assign w_hit     = r_btb_v[w_idx] &&
                     (r_btb_tag[w_idx] == r_pc[31:IW+2]);
  assign w_btb_tgt = r_btb_tgt[w_idx];
  assign w_unused  = btb_upd_pc_i[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_btb_v <= '0;
    end else if (btb_upd_i) begin
      r_btb_v[w_upd_idx] <= 1'b1;
    end
  end

  // Payload needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (btb_upd_i) begin
      r_btb_tag[w_upd_idx] <= btb_upd_pc_i[31:IW+2];
      r_btb_tgt[w_upd_idx] <= btb_upd_target_i;
    end
  end
`else
  logic w_unused;

  assign w_hit     = 1'b0;
  assign w_btb_tgt = 32'h0;
  assign w_unused  = ^{btb_upd_i, btb_upd_pc_i, btb_upd_target_i};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_valid     <= 1'b0;
      r_id_pc     <= 32'h0;
      r_id_pcp4   <= 32'h0;
      r_id_ins    <= NOP_INSTR;
      r_id_pred   <= 1'b0;
      r_fetch_cnt <= 32'h0;
      r_flush_cnt <= 16'h0;
    end else if (redirect_i) begin
      r_pc      <= {redirect_pc_i[31:2], 2'b00};
      r_valid   <= 1'b0;
      r_id_ins  <= NOP_INSTR;
      r_id_pred <= 1'b0;
      if (r_flush_cnt != 16'hFFFF) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end else if (!stall_i) begin
      r_pc        <= w_hit ? w_btb_tgt : w_pcp4;
      r_valid     <= 1'b1;
      r_id_pc     <= r_pc;
      r_id_pcp4   <= w_pcp4;
      r_id_ins    <= imem_rdata_i;
      r_id_pred   <= w_hit;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign imem_addr_o        = r_pc;
  assign pc_o               = r_pc;
  assign if_id_valid_o      = r_valid;
  assign if_id_pc_o         = r_id_pc;
  assign if_id_pcp4_o       = r_id_pcp4;
  assign if_id_ins_o        = r_id_ins;
  assign if_id_pred_taken_o = r_id_pred;
  assign fetch_cnt_o        = r_fetch_cnt;
  assign flush_cnt_o        = r_flush_cnt;

endmodule
